regmux_scan: RTL and testbench

REGMUX_SCAN -- requirements
Module: regmux_scan

---
 rtl/regmux_scan_if.sv | 40 ++++
 rtl/regmux_scan.sv | 101 ++++++++++
 tb/tb_regmux_scan.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/regmux_scan_if.sv
// regmux_scan_if -- bus bundle for the regmux_scan channel multiplexer.
//   D        channel data, channel k at bits [k*DW +: DW]
//   S        direct channel select
//   LE       load enable for the data and select registers
//   MODE     0 = direct select, 1 = auto-scan
//   STEP     scan advance request (auto-scan only)
//   OE1..OE3 output enables for Y/Yn (drive when OE1=0, OE2=0, OE3=1)
//   CH       channel index currently on Y
//   VALID    Y holds data captured since reset
//   WRAP     one-cycle pulse on scan wrap-around
//   SEL_ERR  one-cycle pulse on an out-of-range direct select
interface regmux_scan_if #(
  parameter int N_CH = 8,
  parameter int DW   = 1
);
  localparam int SW = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH*DW-1:0] D;
  logic [SW-1:0]      S;
  logic               LE;
  logic               MODE;
  logic               STEP;
  logic               OE1;
  logic               OE2;
  logic               OE3;
  logic [SW-1:0]      CH;
  logic               VALID;
  logic               WRAP;
  logic               SEL_ERR;

  modport master (
    output D, S, LE, MODE, STEP, OE1, OE2, OE3,
    input  CH, VALID, WRAP, SEL_ERR
  );

  modport slave (
    input  D, S, LE, MODE, STEP, OE1, OE2, OE3,
    output CH, VALID, WRAP, SEL_ERR
  );
endinterface

// File: rtl/regmux_scan.sv
// regmux_scan -- registered N_CH-way channel multiplexer with direct select
// and auto-scan modes, tri-state data outputs.
//   CP   clock, all state changes on the rising edge
//   MR   asynchronous active-high reset
//   bus  regmux_scan_if slave: data/select/mode inputs, CH/VALID/WRAP/SEL_ERR
//   Y    registered selected channel data, high-Z when disabled
//   Yn   complement of Y, high-Z when disabled
// Y/Yn are plain ports so the tri-state drivers sit directly on the module
// boundary; the interface carries only always-driven signals.
module regmux_scan #(
  parameter int N_CH = 8,
  parameter int DW   = 1
) (
  input  logic          CP,
  input  logic          MR,
  regmux_scan_if.slave  bus,
  output wire [DW-1:0]  Y,
  output wire [DW-1:0]  Yn
);
  localparam int SW = (N_CH > 1) ? $clog2(N_CH) : 1;
  // One extra bit so N_CH itself is representable for the range check.
  localparam logic [SW:0]   N_CH_W = (SW+1)'(N_CH);
  localparam logic [SW-1:0] LAST   = SW'(N_CH - 1);

  logic [N_CH*DW-1:0] data_q, data_d;
  logic [SW-1:0]      sel_q, sel_d;
  logic [DW-1:0]      y_q, y_d;
  logic [SW-1:0]      ch_q, ch_d;
  logic               loaded_q, loaded_d;
  logic               valid_q, valid_d;
  logic               wrap_q, wrap_d;
  logic               sel_err_q, sel_err_d;
  logic               oe_on;

  always_comb begin
    data_d    = bus.LE ? bus.D : data_q;
    sel_d     = sel_q;
    wrap_d    = 1'b0;
    sel_err_d = 1'b0;

    if (bus.MODE) begin
      // Scan continues from whatever select is current; S is ignored.
      if (bus.STEP) begin
        if (sel_q == LAST) begin
          sel_d  = '0;
          wrap_d = 1'b1;
        end else begin
          sel_d = sel_q + SW'(1);
        end
      end
    end else if (bus.LE) begin
      if ({1'b0, bus.S} < N_CH_W) begin
        sel_d = bus.S;
      end else begin
        sel_err_d = 1'b1;
      end
    end

    // Output stage reads the registered data/select, giving the two-edge
    // capture-to-output latency with Y and CH always aligned.
    y_d = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (sel_q == SW'(k)) y_d = data_q[k*DW +: DW];
    end
    ch_d     = sel_q;
    loaded_d = loaded_q | bus.LE;
    valid_d  = loaded_q;
  end

  always_ff @(posedge CP or posedge MR) begin
    if (MR) begin
      data_q    <= '0;
      sel_q     <= '0;
      y_q       <= '0;
      ch_q      <= '0;
      loaded_q  <= 1'b0;
      valid_q   <= 1'b0;
      wrap_q    <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      sel_q     <= sel_d;
      y_q       <= y_d;
      ch_q      <= ch_d;
      loaded_q  <= loaded_d;
      valid_q   <= valid_d;
      wrap_q    <= wrap_d;
      sel_err_q <= sel_err_d;
    end
  end

  // Enables are purely combinational and never gate the registers.
  assign oe_on = ~bus.OE1 & ~bus.OE2 & bus.OE3;
  assign Y     = oe_on ? y_q  : {DW{1'bz}};
  assign Yn    = oe_on ? ~y_q : {DW{1'bz}};

  assign bus.CH      = ch_q;
  assign bus.VALID   = valid_q;
  assign bus.WRAP    = wrap_q;
  assign bus.SEL_ERR = sel_err_q;
endmodule

// File: tb/tb_regmux_scan.sv
module tb_regmux_scan;
  logic cp = 1'b0;
  logic mr = 1'b1;
  always #5 cp = ~cp;

  int edges = 0;
  always @(posedge cp) edges <= edges + 1;

  regmux_scan_if #(.N_CH(8), .DW(1)) b8 ();
  regmux_scan_if #(.N_CH(6), .DW(1)) b6 ();
  regmux_scan_if #(.N_CH(4), .DW(8)) b4 ();
  wire [0:0] y8, yn8, y6, yn6;
  wire [7:0] y4, yn4;

  regmux_scan #(.N_CH(8), .DW(1)) u8 (.CP(cp), .MR(mr), .bus(b8), .Y(y8), .Yn(yn8));
  regmux_scan #(.N_CH(6), .DW(1)) u6 (.CP(cp), .MR(mr), .bus(b6), .Y(y6), .Yn(yn6));
  regmux_scan #(.N_CH(4), .DW(8)) u4 (.CP(cp), .MR(mr), .bus(b4), .Y(y4), .Yn(yn4));

  localparam int F_Y = 0, F_YN = 1, F_CH = 2, F_VALID = 3, F_WRAP = 4, F_SERR = 5, F_DRV = 6;

  typedef struct {
    int          at_edge;
    int          dut;
    int          fld;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic string fname(int f);
    case (f)
      F_Y:     return "Y";
      F_YN:    return "Yn";
      F_CH:    return "CH";
      F_VALID: return "VALID";
      F_WRAP:  return "WRAP";
      F_SERR:  return "SEL_ERR";
      default: return "driven";
    endcase
  endfunction

  // "driven" is 1 when Y and Yn are complementary drivers, 0 when floating.
  function automatic logic [31:0] actual(int dut, int fld);
    logic [31:0] r;
    r = '0;
    case (dut)
      0: case (fld)
           F_Y:     r = 32'(y8);
           F_YN:    r = 32'(yn8);
           F_CH:    r = 32'(b8.CH);
           F_VALID: r = 32'(b8.VALID);
           F_WRAP:  r = 32'(b8.WRAP);
           F_SERR:  r = 32'(b8.SEL_ERR);
           default: r = ((y8 ^ yn8) === 1'b1) ? 32'd1 : 32'd0;
         endcase
      1: case (fld)
           F_Y:     r = 32'(y6);
           F_YN:    r = 32'(yn6);
           F_CH:    r = 32'(b6.CH);
           F_VALID: r = 32'(b6.VALID);
           F_WRAP:  r = 32'(b6.WRAP);
           F_SERR:  r = 32'(b6.SEL_ERR);
           default: r = ((y6 ^ yn6) === 1'b1) ? 32'd1 : 32'd0;
         endcase
      default: case (fld)
           F_Y:     r = 32'(y4);
           F_YN:    r = 32'(yn4);
           F_CH:    r = 32'(b4.CH);
           F_VALID: r = 32'(b4.VALID);
           F_WRAP:  r = 32'(b4.WRAP);
           F_SERR:  r = 32'(b4.SEL_ERR);
           default: r = ((y4 ^ yn4) === 8'hFF) ? 32'd1 : 32'd0;
         endcase
    endcase
    return r;
  endfunction

  // Expectation checked at the falling edge after k more rising edges.
  task automatic exp_at(int dut, int fld, int k, logic [31:0] v);
    exp_t e;
    e.at_edge = edges + k;
    e.dut     = dut;
    e.fld     = fld;
    e.val     = v;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge cp);
    #1;
  endtask

  // Monitor: every falling edge, retire all expectations that are due.
  initial begin
    forever begin
      @(negedge cp);
      for (int i = 0; i < sb.size(); ) begin
        if (sb[i].at_edge <= edges) begin
          logic [31:0] a;
          a = actual(sb[i].dut, sb[i].fld);
          n_checks++;
          if (a !== sb[i].val) begin
            n_fail++;
            $display("FAIL dut%0d %s at edge %0d: got %0h expected %0h",
                     sb[i].dut, fname(sb[i].fld), edges, a, sb[i].val);
          end
          sb.delete(i);
        end else begin
          i++;
        end
      end
    end
  end

  // Hand-computed scan table for N_CH=8 starting from select 6.
  int ch_tab  [11] = '{6, 7, 0, 1, 2, 3, 4, 5, 6, 7, 7};
  int wrap_tab[11] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int y_tab   [11] = '{1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0};

  initial begin
    b8.D = '0; b8.S = '0; b8.LE = 0; b8.MODE = 0; b8.STEP = 0;
    b8.OE1 = 0; b8.OE2 = 0; b8.OE3 = 1;
    b6.D = '0; b6.S = '0; b6.LE = 0; b6.MODE = 0; b6.STEP = 0;
    b6.OE1 = 0; b6.OE2 = 0; b6.OE3 = 1;
    b4.D = '0; b4.S = '0; b4.LE = 0; b4.MODE = 0; b4.STEP = 0;
    b4.OE1 = 0; b4.OE2 = 0; b4.OE3 = 1;

    // Reset state while MR is held
    step();
    n_checks++;
    if (y8 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: y8=%0b expected 0", y8);
    end
    n_checks++;
    if (yn8 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset: yn8=%0b expected 1", yn8);
    end
    n_checks++;
    if (b8.CH !== 3'd0) begin
      n_fail++;
      $display("FAIL reset: CH=%0d expected 0", b8.CH);
    end
    n_checks++;
    if (b8.VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: VALID=%0b expected 0", b8.VALID);
    end
    n_checks++;
    if (y4 !== 8'h00) begin
      n_fail++;
      $display("FAIL reset: y4=%0h expected 00", y4);
    end
    exp_at(0, F_Y, 0, 0);     exp_at(0, F_YN, 0, 1);   exp_at(0, F_CH, 0, 0);
    exp_at(0, F_VALID, 0, 0); exp_at(0, F_WRAP, 0, 0); exp_at(0, F_SERR, 0, 0);
    exp_at(0, F_DRV, 0, 1);
    exp_at(2, F_Y, 0, 0);     exp_at(2, F_YN, 0, 32'hFF);
    @(negedge cp); #1 mr = 1'b0;
    step();

    // Direct select, two-edge latency
    b8.D = 8'b1010_1100; b8.S = 3'd3; b8.LE = 1;
    exp_at(0, F_VALID, 1, 0); exp_at(0, F_CH, 1, 0);
    exp_at(0, F_Y, 2, 1); exp_at(0, F_YN, 2, 0); exp_at(0, F_CH, 2, 3); exp_at(0, F_VALID, 2, 1);
    step();
    b8.LE = 0; b8.D = '0; b8.S = 3'd5;
    exp_at(0, F_Y, 2, 1); exp_at(0, F_CH, 2, 3);
    step(); step(); step();

    // Output enable combinations
    b8.OE1 = 1;
    exp_at(0, F_DRV, 0, 0); exp_at(0, F_CH, 0, 3); exp_at(0, F_VALID, 0, 1);
    step();
    b8.OE1 = 0; b8.OE2 = 1;
    exp_at(0, F_DRV, 0, 0); exp_at(0, F_CH, 0, 3);
    step();
    b8.OE2 = 0; b8.OE3 = 0;
    exp_at(0, F_DRV, 0, 0); exp_at(0, F_VALID, 0, 1);
    step();
    b8.OE3 = 1;
    exp_at(0, F_DRV, 0, 1); exp_at(0, F_Y, 0, 1); exp_at(0, F_YN, 0, 0);
    step();

    // Auto-scan from channel 6 through the wrap
    b8.D = 8'b0100_0001; b8.S = 3'd6; b8.LE = 1;
    step();
    b8.LE = 0; b8.MODE = 1; b8.STEP = 1;
    for (int j = 0; j < 11; j++) begin
      exp_at(0, F_CH,   j + 1, 32'(ch_tab[j]));
      exp_at(0, F_WRAP, j + 1, 32'(wrap_tab[j]));
      exp_at(0, F_Y,    j + 1, 32'(y_tab[j]));
    end
    repeat (9) step();
    b8.STEP = 0;
    step(); step();

    // Asynchronous reset in the middle of a scan (select 7 -> 0 with WRAP)
    b8.STEP = 1;
    step();
    #1 mr = 1'b1;
    exp_at(0, F_CH, 0, 0); exp_at(0, F_WRAP, 0, 0); exp_at(0, F_VALID, 0, 0);
    exp_at(0, F_Y, 0, 0);  exp_at(0, F_YN, 0, 1);   exp_at(0, F_SERR, 0, 0);
    @(negedge cp); #1 mr = 1'b0;
    exp_at(0, F_CH, 1, 0); exp_at(0, F_WRAP, 1, 0); exp_at(0, F_VALID, 1, 0);
    exp_at(0, F_CH, 2, 1); exp_at(0, F_Y, 2, 0);
    step(); step();
    b8.STEP = 0; b8.MODE = 0;
    step();

    // N_CH=6: out-of-range selects, in-range reload, S ignored with LE=0
    b6.D = 6'b10_0100; b6.S = 3'd2; b6.LE = 1;
    exp_at(1, F_SERR, 1, 0); exp_at(1, F_CH, 2, 2); exp_at(1, F_Y, 2, 1);
    step();
    b6.S = 3'd7;
    exp_at(1, F_SERR, 1, 1); exp_at(1, F_CH, 2, 2); exp_at(1, F_CH, 3, 2);
    step();
    b6.S = 3'd6;
    exp_at(1, F_SERR, 1, 1);
    step();
    b6.S = 3'd5;
    exp_at(1, F_SERR, 1, 0); exp_at(1, F_CH, 2, 5); exp_at(1, F_Y, 2, 1); exp_at(1, F_YN, 2, 0);
    step();
    b6.LE = 0; b6.S = 3'd1;
    exp_at(1, F_CH, 2, 5); exp_at(1, F_CH, 3, 5); exp_at(1, F_SERR, 1, 0);
    step(); step(); step();
    // Non-power-of-two wrap at 5 -> 0
    b6.MODE = 1; b6.STEP = 1;
    exp_at(1, F_WRAP, 1, 1); exp_at(1, F_CH, 1, 5);
    exp_at(1, F_WRAP, 2, 0); exp_at(1, F_CH, 2, 0); exp_at(1, F_Y, 2, 0);
    step();
    b6.STEP = 0; b6.MODE = 0;
    step();

    // N_CH=4, DW=8 wide channels
    b4.D = 32'hDEAD_BEEF; b4.S = 2'd2; b4.LE = 1;
    exp_at(2, F_VALID, 1, 0);
    exp_at(2, F_Y, 2, 32'hAD); exp_at(2, F_YN, 2, 32'h52); exp_at(2, F_CH, 2, 2); exp_at(2, F_VALID, 2, 1);
    step();
    b4.S = 2'd3;
    exp_at(2, F_Y, 2, 32'hDE); exp_at(2, F_CH, 2, 3);
    step();
    b4.LE = 0; b4.MODE = 1; b4.STEP = 1;
    exp_at(2, F_WRAP, 1, 1);
    exp_at(2, F_WRAP, 2, 0); exp_at(2, F_CH, 2, 0); exp_at(2, F_Y, 2, 32'hEF);
    step();
    b4.STEP = 0;
    step(); step(); step();

    for (int w = 0; w < 50 && sb.size() > 0; w++) @(posedge cp);
    #1;
    while (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout dut%0d %s: never checked, expected %0h",
               sb[0].dut, fname(sb[0].fld), sb[0].val);
      void'(sb.pop_front());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
